// File: rtl/alu_ctrl_pkg.sv
// Shared opcode/funct encodings, ALU control codes and mul/div engine types
// for the EX-stage ALU controller with HI/LO and sequential mul/div.
package alu_ctrl_pkg;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

  // Encoding follows funct[1:0] of MULT/MULTU/DIV/DIVU.
  typedef enum logic [1:0] {MUL, MULU, DIV, DIVU} md_op_t;

endpackage

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide engine: one bit per cycle on operand magnitudes,
// sign fix-up in FIX, result presented while in FIX.
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | WIDTH shift-add / restoring-subtract steps
//   FIX   | sign correction; top writes HI/LO on the exit edge
module muldiv_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  md_op_t           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             fix_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);

  md_state_t          r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem, r_q, r_mag_b, r_a;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_done;

  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_dif, w_quo, w_rmd;
  logic [WIDTH:0]     w_sum, w_shl;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed = (op_i == MUL) || (op_i == DIV);
  assign w_mag_a  = (w_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_mag_b  = (w_signed && b_i[WIDTH-1]) ? -b_i : b_i;

  assign w_sum = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_mag_b} : '0);
  assign w_shl = {r_rem, r_q[WIDTH-1]};
  assign w_ge  = w_shl >= {1'b0, r_mag_b};
  // Remainder after a successful subtract is below the divisor, so W bits suffice.
  assign w_dif = w_shl[WIDTH-1:0] - r_mag_b;

  assign w_prod = r_neg_q ? -{r_rem, r_q} : {r_rem, r_q};
  assign w_quo  = r_neg_q ? -r_q : r_q;
  assign w_rmd  = r_neg_r ? -r_rem : r_rem;

  assign hi_o = r_is_div ? (r_dz ? r_a : w_rmd) : w_prod[2*WIDTH-1:WIDTH];
  assign lo_o = r_is_div ? (r_dz ? '1 : w_quo) : w_prod[WIDTH-1:0];

  assign busy_o = (r_state != IDLE);
  assign fix_o  = (r_state == FIX);
  assign done_o = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_mag_b  <= '0;
      r_a      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start_i) begin
          r_state  <= RUN;
          r_cnt    <= CW'(WIDTH - 1);
          r_rem    <= '0;
          r_q      <= w_mag_a;
          r_mag_b  <= w_mag_b;
          r_a      <= a_i;
          r_is_div <= (op_i == DIV) || (op_i == DIVU);
          r_neg_q  <= w_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          r_neg_r  <= w_signed && a_i[WIDTH-1];
          r_dz     <= ((op_i == DIV) || (op_i == DIVU)) && (b_i == '0);
        end
        RUN: begin
          if (r_is_div) begin
            r_rem <= w_ge ? w_dif : w_shl[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_rem <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        FIX: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decoder with HI/LO registers, MT/MF handling and
// hazard stall toward the pipeline while the mul/div engine is busy.
module alu_ctrl_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [1:0]        alu_op_i,
  input  logic [5:0]        funct_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic              illegal_o,
  output logic              hilo_sel_o,
  output logic [WIDTH-1:0]  hilo_rd_o,
  output logic              stall_o,
  output logic              md_busy_o,
  output logic              md_done_o,
  output logic [WIDTH-1:0]  hi_o,
  output logic [WIDTH-1:0]  lo_o
);
  logic             w_rtype, w_hl_funct, w_md_funct, w_go, w_start, w_busy, w_fix;
  logic [3:0]       w_code;
  logic [WIDTH-1:0] w_md_hi, w_md_lo;
  logic [WIDTH-1:0] r_hi, r_lo;
  md_op_t           w_op;

  assign w_rtype    = alu_op_i[1];
  assign w_hl_funct = funct_i inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                      F_MULT, F_MULTU, F_DIV, F_DIVU};
  assign w_md_funct = funct_i inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  assign stall_o    = en_i & w_rtype & w_hl_funct & w_busy;
  assign w_go       = en_i & w_rtype & ~w_busy;
  assign w_start    = w_go & w_md_funct;
  assign w_op       = md_op_t'(funct_i[1:0]);

  always_comb begin
    w_code    = ALU_ADD;
    illegal_o = 1'b0;
    if (w_rtype) begin
      case (funct_i)
        F_ADD, F_ADDU: w_code = ALU_ADD;
        F_SUB, F_SUBU: w_code = ALU_SUB;
        F_AND:         w_code = ALU_AND;
        F_OR:          w_code = ALU_OR;
        F_XOR:         w_code = ALU_XOR;
        F_NOR:         w_code = ALU_NOR;
        F_SLT:         w_code = ALU_SLT;
        F_SLTU:        w_code = ALU_SLTU;
        F_SLL:         w_code = ALU_SLL;
        F_SRL:         w_code = ALU_SRL;
        F_SRA:         w_code = ALU_SRA;
        F_MFHI, F_MTHI, F_MFLO, F_MTLO,
        F_MULT, F_MULTU, F_DIV, F_DIVU: w_code = ALU_ADD;
        default:       illegal_o = en_i;
      endcase
    end else if (alu_op_i[0]) begin
      w_code = ALU_SUB;
    end
  end

  assign alu_ctrl_o = CTRL_W'(w_code);
  assign hilo_sel_o = en_i & w_rtype & ((funct_i == F_MFHI) | (funct_i == F_MFLO));
  assign hilo_rd_o  = !hilo_sel_o ? '0 : ((funct_i == F_MFHI) ? r_hi : r_lo);

  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (w_start),
    .op_i    (w_op),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (w_busy),
    .fix_o   (w_fix),
    .done_o  (md_done_o),
    .hi_o    (w_md_hi),
    .lo_o    (w_md_lo)
  );

  // MT writes only happen when idle, so they never collide with the FIX write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fix) begin
      r_hi <= w_md_hi;
      r_lo <= w_md_lo;
    end else if (w_go && (funct_i == F_MTHI)) begin
      r_hi <= a_i;
    end else if (w_go && (funct_i == F_MTLO)) begin
      r_lo <= a_i;
    end
  end

  assign md_busy_o = w_busy;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Scoreboard bench for alu_ctrl_muldiv: decode checks, MT/MF, stall timing,
// and randomized mul/div against an arithmetic reference model.
module tb_alu_ctrl_muldiv;
  localparam int W = 32;

  localparam logic [5:0] T_MFHI = 6'b010000, T_MTHI = 6'b010001;
  localparam logic [5:0] T_MFLO = 6'b010010, T_MTLO = 6'b010011;
  localparam logic [5:0] T_MULT = 6'b011000, T_MULTU = 6'b011001;
  localparam logic [5:0] T_DIV  = 6'b011010, T_DIVU  = 6'b011011;

  logic clk = 1'b0, rst_n = 1'b0, en_i = 1'b0;
  logic [1:0] alu_op_i = 2'b00;
  logic [5:0] funct_i = 6'b100000;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic [3:0] alu_ctrl_o;
  logic illegal_o, hilo_sel_o, stall_o, md_busy_o, md_done_o;
  logic [W-1:0] hilo_rd_o, hi_o, lo_o;

  int n_checks = 0, n_err = 0, cyc = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           start;
  } exp_t;
  exp_t sb[$];

  alu_ctrl_muldiv #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .alu_op_i(alu_op_i), .funct_i(funct_i),
    .a_i(a_i), .b_i(b_i), .alu_ctrl_o(alu_ctrl_o), .illegal_o(illegal_o),
    .hilo_sel_o(hilo_sel_o), .hilo_rd_o(hilo_rd_o), .stall_o(stall_o),
    .md_busy_o(md_busy_o), .md_done_o(md_done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and % takes the dividend's sign, matching the architectural rules.
  function automatic exp_t model(logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sbv = $signed(b);
    p = '0;
    if (f == T_MULT) p = sa * sbv;
    else if (f == T_MULTU) p = {32'b0, a} * {32'b0, b};
    else if (b == '0) p = {a, {W{1'b1}}};
    else if (f == T_DIV) begin
      q = sa / sbv; r = sa % sbv; p = {r[31:0], q[31:0]};
    end else begin
      q = longint'({32'b0, a}) / longint'({32'b0, b});
      r = longint'({32'b0, a}) % longint'({32'b0, b});
      p = {r[31:0], q[31:0]};
    end
    e.hi = p[63:32];
    e.lo = p[31:0];
    e.start = 0;
    return e;
  endfunction

  // Monitor: pops an expectation whenever the engine reports completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) sb.delete();
    else if (md_done_o) begin
      if (sb.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL done_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("md_hi", hi_o, e.hi);
        check("md_lo", lo_o, e.lo);
        check("md_latency", cyc - e.start, W + 1);
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    en_i = 1'b1; alu_op_i = 2'b10; funct_i = f; a_i = a; b_i = b;
    #1;
    check("issue_stall", stall_o, 0);
    check("issue_ctrl", alu_ctrl_o, 4'b0010);
    check("issue_illegal", illegal_o, 0);
    e = model(f, a, b);
    @(posedge clk); #1;
    e.start = cyc;
    sb.push_back(e);
    en_i = 1'b0; funct_i = 6'b100000;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (md_busy_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("busy_timeout", md_busy_o, 0);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] dec_f [14];
    logic [3:0] dec_c [14];
    logic [5:0] md_f [4];
    exp_t e;
    int st, first, n_st;
    logic [W-1:0] saved_hi;

    dec_f = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
              6'h00, 6'h02, 6'h03, 6'h3F};
    dec_c = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'h3, 4'hC, 4'h7, 4'hF,
              4'h8, 4'h9, 4'hA, 4'h2};
    md_f = '{T_MULT, T_MULTU, T_DIV, T_DIVU};

    // Reset state and non-R-type decode
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_busy", md_busy_o, 0);
    check("rst_done", md_done_o, 0);
    check("rst_stall", stall_o, 0);
    alu_op_i = 2'b00; en_i = 1'b1; #1;
    check("aluop00", alu_ctrl_o, 4'b0010);
    alu_op_i = 2'b01; #1;
    check("aluop01", alu_ctrl_o, 4'b0110);
    check("aluop01_illegal", illegal_o, 0);

    // R-type decode sweep, last entry is an unknown funct
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      alu_op_i = 2'b10; funct_i = dec_f[i]; en_i = 1'b1; #1;
      check($sformatf("dec_%02h", dec_f[i]), alu_ctrl_o, dec_c[i]);
      check($sformatf("ill_%02h", dec_f[i]), illegal_o, (i == 13) ? 1 : 0);
    end
    en_i = 1'b0; #1;
    check("ill_en0", illegal_o, 0);

    // Flushed mul/div must not start the engine
    @(negedge clk); funct_i = T_MULT; a_i = 5; b_i = 5;
    @(posedge clk); #1;
    check("flush_nostart", md_busy_o, 0);

    // Directed mul/div corners
    issue(T_MULT, -32'sd3, 32'd7);                  wait_idle();
    issue(T_MULTU, 32'hFFFF_FFFF, 32'd2);           wait_idle();
    issue(T_DIV, -32'sd7, 32'd2);                   wait_idle();
    issue(T_DIVU, 32'd7, 32'd0);                    wait_idle();
    issue(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);     wait_idle();
    issue(T_DIV, -32'sd9, 32'd0);                   wait_idle();

    // MFLO 5 cycles after MULT stalls until the done cycle, then reads new LO
    e = model(T_MULT, 32'd1234, -32'sd567);
    issue(T_MULT, 32'd1234, -32'sd567);
    st = cyc;
    while (cyc < st + 5) @(negedge clk);
    en_i = 1'b1; alu_op_i = 2'b10; funct_i = T_MFLO; #1;
    first = cyc; n_st = 0;
    while (stall_o && n_st < 100) begin n_st++; @(negedge clk); #1; end
    check("mflo_stall_cycles", n_st, st + W - first + 1);
    check("mflo_done_cycle", md_done_o, 1);
    check("mflo_sel", hilo_sel_o, 1);
    check("mflo_read", hilo_rd_o, e.lo);
    @(negedge clk); en_i = 1'b0; funct_i = 6'b100000;

    // MTHI while busy stalls and leaves HI untouched
    saved_hi = hi_o;
    issue(T_MULTU, 32'h0001_0003, 32'h0002_0005);
    repeat (3) @(negedge clk);
    en_i = 1'b1; funct_i = T_MTHI; a_i = 32'h1234_5678; #1;
    check("mthi_busy_stall", stall_o, 1);
    @(posedge clk); #1;
    check("mthi_busy_nowrite", hi_o, saved_hi);
    en_i = 1'b0; funct_i = 6'b100000;
    wait_idle();

    // Idle MTHI/MTLO writes and MFHI/MFLO reads
    @(negedge clk); en_i = 1'b1; funct_i = T_MTHI; a_i = 32'hCAFE_0001;
    @(posedge clk); #1;
    check("mthi_write", hi_o, 32'hCAFE_0001);
    funct_i = T_MTLO; a_i = 32'hBEEF_0002;
    @(posedge clk); #1;
    check("mtlo_write", lo_o, 32'hBEEF_0002);
    check("mtlo_keeps_hi", hi_o, 32'hCAFE_0001);
    funct_i = T_MFHI; #1;
    check("mfhi_sel", hilo_sel_o, 1);
    check("mfhi_read", hilo_rd_o, 32'hCAFE_0001);
    funct_i = T_MFLO; #1;
    check("mflo_idle_read", hilo_rd_o, 32'hBEEF_0002);
    en_i = 1'b0; #1;
    check("mf_en0_sel", hilo_sel_o, 0);
    check("mf_en0_rd", hilo_rd_o, 0);
    funct_i = 6'b100000;

    // Async reset mid-RUN discards the operation
    issue(T_MULT, 32'd77, 32'd88);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0; #1;
    sb.delete();
    check("midrst_busy", md_busy_o, 0);
    check("midrst_done", md_done_o, 0);
    check("midrst_hi", hi_o, 0);
    check("midrst_lo", lo_o, 0);
    @(negedge clk); rst_n = 1'b1;
    issue(T_MULT, -32'sd5, -32'sd9); wait_idle();

    // Randomized mul/div
    for (int i = 0; i < 40; i++) begin
      issue(md_f[$urandom_range(0, 3)], pick(), pick());
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
